noc_local_ni: RTL and testbench

- Local network interface that sits between a processing core and the router's L (local) port.
- Injection side: packs core requests into 40-bit flits (src/dst/timestamp/data/type) and drives them into the router's local input, honouring the router's `full` backpressure.
- Ejection side: accepts flits from the router's local output, checks the destination, computes network latency from the embedded timestamp, and buffers them in a small RX FIFO for the core.

---
 rtl/noc_local_ni.sv | 268 ++++++++++++++++++++++++++
 tb/tb_noc_local_ni.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_ni.sv
// -----------------------------------------------------------------------------
// noc_local_ni
//
// Local network interface between a processing core and the router's L port.
//
//   Injection: a core request (tx_valid/tx_ready) is packed into a 40-bit flit
//   {src=ID, dst, timestamp=now, payload, type} held in a single output
//   register that drives the router local input (L_data_in/L_valid_in) under
//   the router's `full` backpressure.
//
//   Ejection: every flit presented on L_data_out/L_valid_out is checked for
//   destination. Flits addressed elsewhere, or arriving while the RX FIFO is
//   full with no pop that cycle, are dropped and counted in err_count.
//   Accepted flits are stored as {src, type, data, latency}. Latency is
//   (now - timestamp) mod 256.
//
// Handshake semantics (both core-side channels):
//   A transfer happens on a rising edge where valid=1 and ready=1.
//   tx: the core may change tx_* freely while tx_ready=0; no request is taken.
//   rx: rx_valid=1 means the head fields are meaningful; rx_ready=1 pops the
//       head on that edge. The router side uses !full as its ready.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   ID                         local node ID
//   tx_valid/tx_ready          core request handshake
//   tx_dst/tx_type/tx_payload  request fields
//   L_data_in/L_valid_in       flit to router local input
//   full                       router local input FIFO full
//   L_data_out/L_valid_out     flit from router local output
//   rx_valid/rx_ready          RX FIFO head handshake
//   rx_src/rx_type/rx_payload/rx_latency   head flit fields
//   rx_full                    RX FIFO holds RX_DEPTH entries
//   tx_count/rx_count          wrapping packet counters
//   err_count                  saturating drop counter
//   dbg_tx_state               TX FSM state (0=IDLE, 1=SEND)
//
// Optional feature (macro NOC_NI_LATENCY_STAT_EN):
//   lat_max  running maximum latency of accepted RX flits
//   lat_sum  saturating sum of latencies of accepted RX flits
//
// RX_DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module noc_local_ni #(
  parameter int DATASIZE = 40,
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          ID,
  // core injection request
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [3:0]          tx_dst,
  input  logic [1:0]          tx_type,
  input  logic [21:0]         tx_payload,
  // router local input
  output logic [DATASIZE-1:0] L_data_in,
  output logic                L_valid_in,
  input  logic                full,
  // router local output
  input  logic [DATASIZE-1:0] L_data_out,
  input  logic                L_valid_out,
  // core ejection FIFO head
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic [3:0]          rx_src,
  output logic [1:0]          rx_type,
  output logic [21:0]         rx_payload,
  output logic [7:0]          rx_latency,
  output logic                rx_full,
  // statistics
  output logic [CNT_W-1:0]    tx_count,
  output logic [CNT_W-1:0]    rx_count,
  output logic [7:0]          err_count,
`ifdef NOC_NI_LATENCY_STAT_EN
  output logic [7:0]          lat_max,
  output logic [23:0]         lat_sum,
`endif
  output logic                dbg_tx_state
);

  localparam int AW = $clog2(RX_DEPTH);
  localparam int PW = AW + 1;
  // RX entry: {src[4], type[2], data[22], latency[8]}
  localparam int EW = 36;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  // ---------------------------------------------------------------------------
  // Timestamp counter
  // ---------------------------------------------------------------------------
  logic [7:0] r_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_now <= 8'd0;
    end else begin
      r_now <= r_now + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Injection path
  // ---------------------------------------------------------------------------
  logic [0:0]          r_state;
  logic [DATASIZE-1:0] r_tx_flit;
  logic                r_tx_valid;
  logic [CNT_W-1:0]    r_tx_count;

  logic                w_tx_xfer;
  logic                w_tx_ready;
  logic [DATASIZE-1:0] w_tx_new;

  // The output register is occupied exactly while in SEND, so a transfer is
  // simply "holding a flit and router not full".
  assign w_tx_xfer = r_tx_valid & ~full;

  // In SEND the slot frees up on the same edge it drains, which is what
  // allows one flit per cycle. Ready is forced low while reset is asserted.
  assign w_tx_ready = rst_n & ((r_state == S_IDLE) | ~full);

  // Timestamp is taken when the request is accepted, not when it leaves.
  assign w_tx_new = {ID, tx_dst, r_now, tx_payload, tx_type};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tx_flit  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_xfer) begin
        r_tx_count <= r_tx_count + CNT_W'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_tx_flit  <= w_tx_new;
            r_tx_valid <= 1'b1;
            r_state    <= S_SEND;
          end
        end
        S_SEND: begin
          // While full, flit and valid hold.
          if (!full) begin
            if (tx_valid) begin
              r_tx_flit <= w_tx_new;
            end else begin
              r_tx_valid <= 1'b0;
              r_state    <= S_IDLE;
            end
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_ready     = w_tx_ready;
  assign L_data_in    = r_tx_flit;
  assign L_valid_in   = r_tx_valid;
  assign tx_count     = r_tx_count;
  assign dbg_tx_state = r_state[0];

  // ---------------------------------------------------------------------------
  // Ejection path and RX FIFO
  // ---------------------------------------------------------------------------
  logic [EW-1:0]    r_mem [RX_DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CNT_W-1:0] r_rx_count;
  logic [7:0]       r_err;

  logic [PW-1:0]    w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_hit;
  logic             w_push;
  logic             w_drop;
  logic [7:0]       w_latency;
  logic [EW-1:0]    w_entry;
  logic [EW-1:0]    w_head;

  // Extra pointer bit distinguishes full from empty.
  assign w_count = r_wr - r_rd;
  assign w_empty = (w_count == '0);
  assign w_full  = (w_count == PW'(RX_DEPTH));
  assign w_pop   = ~w_empty & rx_ready;

  assign w_hit   = L_valid_out & (L_data_out[35:32] == ID);
  // When full, a same-cycle pop frees the slot the push lands in.
  assign w_push  = w_hit & (~w_full | w_pop);
  assign w_drop  = L_valid_out & ~w_push;

  // 8-bit subtraction wraps naturally across the timestamp rollover.
  assign w_latency = r_now - L_data_out[31:24];
  assign w_entry   = {L_data_out[39:36], L_data_out[1:0], L_data_out[23:2], w_latency};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RX_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr       <= '0;
      r_rd       <= '0;
      r_rx_count <= '0;
      r_err      <= 8'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr[AW-1:0]] <= w_entry;
        r_wr                <= r_wr + PW'(1);
        r_rx_count          <= r_rx_count + CNT_W'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      if (w_drop && (r_err != 8'hFF)) begin
        r_err <= r_err + 8'd1;
      end
    end
  end

  // Head fields come straight from the storage flops, so a write is visible
  // on the cycle after it and everything reads zero out of reset.
  assign w_head     = r_mem[r_rd[AW-1:0]];
  assign rx_src     = w_head[35:32];
  assign rx_type    = w_head[31:30];
  assign rx_payload = w_head[29:8];
  assign rx_latency = w_head[7:0];
  assign rx_valid   = ~w_empty;
  assign rx_full    = w_full;
  assign rx_count   = r_rx_count;
  assign err_count  = r_err;

`ifdef NOC_NI_LATENCY_STAT_EN
  // ---------------------------------------------------------------------------
  // Latency statistics over accepted RX flits
  // ---------------------------------------------------------------------------
  logic [7:0]  r_lat_max;
  logic [23:0] r_lat_sum;
  logic [24:0] w_sum_ext;

  assign w_sum_ext = {1'b0, r_lat_sum} + {17'd0, w_latency};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat_max <= 8'd0;
      r_lat_sum <= 24'd0;
    end else if (w_push) begin
      if (w_latency > r_lat_max) begin
        r_lat_max <= w_latency;
      end
      r_lat_sum <= w_sum_ext[24] ? 24'hFF_FFFF : w_sum_ext[23:0];
    end
  end

  assign lat_max = r_lat_max;
  assign lat_sum = r_lat_sum;
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
// -----------------------------------------------------------------------------
// tb_noc_local_ni
//
// Self-checking bench for noc_local_ni. A behavioural model tracks the flit
// waiting toward the router (a queue of at most one entry), the RX FIFO
// contents (a queue of entries), the timestamp and the counters. Inputs are
// driven at the falling edge, the model advances right after each rising
// edge, and outputs are compared at the next falling edge.
// -----------------------------------------------------------------------------
module tb_noc_local_ni;

  localparam int DATASIZE = 40;
  localparam int RX_DEPTH = 4;
  localparam int CNT_W    = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic [3:0]          node_id;
  logic                tx_valid;
  logic                tx_ready;
  logic [3:0]          tx_dst;
  logic [1:0]          tx_type;
  logic [21:0]         tx_payload;
  logic [DATASIZE-1:0] L_data_in;
  logic                L_valid_in;
  logic                full;
  logic [DATASIZE-1:0] L_data_out;
  logic                L_valid_out;
  logic                rx_valid;
  logic                rx_ready;
  logic [3:0]          rx_src;
  logic [1:0]          rx_type;
  logic [21:0]         rx_payload;
  logic [7:0]          rx_latency;
  logic                rx_full;
  logic [CNT_W-1:0]    tx_count;
  logic [CNT_W-1:0]    rx_count;
  logic [7:0]          err_count;
  logic                dbg_tx_state;
`ifdef NOC_NI_LATENCY_STAT_EN
  logic [7:0]          lat_max;
  logic [23:0]         lat_sum;
`endif

  noc_local_ni #(
    .DATASIZE (DATASIZE),
    .RX_DEPTH (RX_DEPTH),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ID           (node_id),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_dst       (tx_dst),
    .tx_type      (tx_type),
    .tx_payload   (tx_payload),
    .L_data_in    (L_data_in),
    .L_valid_in   (L_valid_in),
    .full         (full),
    .L_data_out   (L_data_out),
    .L_valid_out  (L_valid_out),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_src       (rx_src),
    .rx_type      (rx_type),
    .rx_payload   (rx_payload),
    .rx_latency   (rx_latency),
    .rx_full      (rx_full),
    .tx_count     (tx_count),
    .rx_count     (rx_count),
    .err_count    (err_count),
`ifdef NOC_NI_LATENCY_STAT_EN
    .lat_max      (lat_max),
    .lat_sum      (lat_sum),
`endif
    .dbg_tx_state (dbg_tx_state)
  );

  // ---------------------------------------------------------------------------
  // Reference model / scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [3:0]  src;
    logic [1:0]  typ;
    logic [21:0] data;
    logic [7:0]  lat;
  } rx_ent_t;

  logic [DATASIZE-1:0] exp_q[$];     // flit waiting toward the router
  rx_ent_t             rx_exp_q[$];  // RX FIFO contents, head first
  logic [7:0]          m_now;
  logic [CNT_W-1:0]    m_tx_cnt;
  logic [CNT_W-1:0]    m_rx_cnt;
  int                  m_err;
`ifdef NOC_NI_LATENCY_STAT_EN
  int                  m_lat_max;
  longint              m_lat_sum;
`endif

  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    rx_exp_q.delete();
    m_now    = 8'd0;
    m_tx_cnt = '0;
    m_rx_cnt = '0;
    m_err    = 0;
`ifdef NOC_NI_LATENCY_STAT_EN
    m_lat_max = 0;
    m_lat_sum = 0;
`endif
  endtask

  // One rising edge of the reference behaviour, using the inputs as driven.
  task automatic model_edge();
    bit      xfer;
    bit      acc;
    bit      pop;
    rx_ent_t e;
    xfer = (exp_q.size() != 0) && !full;
    acc  = tx_valid && ((exp_q.size() == 0) || !full);
    if (xfer) begin
      void'(exp_q.pop_front());
      m_tx_cnt++;
    end
    if (acc) exp_q.push_back({node_id, tx_dst, m_now, tx_payload, tx_type});

    pop = (rx_exp_q.size() != 0) && rx_ready;
    if (L_valid_out) begin
      if (L_data_out[35:32] != node_id) begin
        if (m_err < 255) m_err++;
      end else if ((rx_exp_q.size() == RX_DEPTH) && !pop) begin
        if (m_err < 255) m_err++;
      end else begin
        e.src  = L_data_out[39:36];
        e.typ  = L_data_out[1:0];
        e.data = L_data_out[23:2];
        e.lat  = m_now - L_data_out[31:24];
        if (pop) void'(rx_exp_q.pop_front());
        pop = 1'b0;
        rx_exp_q.push_back(e);
        m_rx_cnt++;
`ifdef NOC_NI_LATENCY_STAT_EN
        if (int'(e.lat) > m_lat_max) m_lat_max = int'(e.lat);
        m_lat_sum = m_lat_sum + longint'(e.lat);
        if (m_lat_sum > 64'hFF_FFFF) m_lat_sum = 64'hFF_FFFF;
`endif
      end
    end
    if (pop) void'(rx_exp_q.pop_front());
    m_now = m_now + 8'd1;
  endtask

  task automatic check_all();
    chk("tx_ready", tx_ready, (exp_q.size() == 0) || !full);
    chk("l_valid_in", L_valid_in, exp_q.size() != 0);
    chk("tx_state", dbg_tx_state, exp_q.size() != 0);
    if (exp_q.size() != 0) chk("l_data_in", L_data_in, exp_q[0]);
    chk("tx_count", tx_count, m_tx_cnt);
    chk("rx_valid", rx_valid, rx_exp_q.size() != 0);
    chk("rx_full", rx_full, rx_exp_q.size() == RX_DEPTH);
    chk("rx_count", rx_count, m_rx_cnt);
    chk("err_count", err_count, m_err);
    if (rx_exp_q.size() != 0) begin
      chk("rx_src", rx_src, rx_exp_q[0].src);
      chk("rx_type", rx_type, rx_exp_q[0].typ);
      chk("rx_payload", rx_payload, rx_exp_q[0].data);
      chk("rx_latency", rx_latency, rx_exp_q[0].lat);
    end
`ifdef NOC_NI_LATENCY_STAT_EN
    chk("lat_max", lat_max, m_lat_max);
    chk("lat_sum", lat_sum, m_lat_sum);
`endif
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic inputs_idle();
    tx_valid    = 1'b0;
    tx_dst      = 4'd0;
    tx_type     = 2'd0;
    tx_payload  = 22'd0;
    full        = 1'b0;
    L_data_out  = '0;
    L_valid_out = 1'b0;
    rx_ready    = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    inputs_idle();
    repeat (n) cycle();
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_l_valid_in"}, L_valid_in, 1'b0);
    chk({tag, "_l_data_in"}, L_data_in, 40'd0);
    chk({tag, "_tx_ready"}, tx_ready, 1'b0);
    chk({tag, "_rx_valid"}, rx_valid, 1'b0);
    chk({tag, "_tx_count"}, tx_count, 16'd0);
    chk({tag, "_rx_count"}, rx_count, 16'd0);
    chk({tag, "_err_count"}, err_count, 8'd0);
  endtask

  task automatic hold_and_release(input logic [3:0] id);
    inputs_idle();
    node_id = id;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic apply_reset(input logic [3:0] id);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_reset_zero("rst");
    hold_and_release(id);
  endtask

  task automatic send_rx(input logic [3:0] src, input logic [3:0] dst,
                         input logic [7:0] ts, input logic [21:0] data,
                         input logic [1:0] typ);
    L_valid_out = 1'b1;
    L_data_out  = {src, dst, ts, data, typ};
    cycle();
    L_valid_out = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [DATASIZE-1:0] basic_flit;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    node_id  = 4'd0;
    inputs_idle();
    model_clear();

    // Basic send: accept with now=5.
    apply_reset(4'd3);
    idle(5);
    tx_valid   = 1'b1;
    tx_dst     = 4'd7;
    tx_payload = 22'h1ABCD;
    tx_type    = 2'b01;
    cycle();
    basic_flit = {4'h3, 4'h7, 8'h05, 22'h1ABCD, 2'b01};
    chk("basic_valid", L_valid_in, 1'b1);
    chk("basic_data", L_data_in, basic_flit);
    tx_valid = 1'b0;
    cycle();
    chk("basic_tx_count", tx_count, 16'd1);
    chk("basic_idle", L_valid_in, 1'b0);

    // Backpressure: 4 cycles of full while SEND.
    tx_valid   = 1'b1;
    tx_dst     = 4'd9;
    tx_payload = 22'h2A5A5;
    tx_type    = 2'b11;
    cycle();
    tx_valid = 1'b0;
    full     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("bp_tx_ready", tx_ready, 1'b0);
      chk("bp_tx_count", tx_count, 16'd1);
      chk("bp_valid", L_valid_in, 1'b1);
    end
    full = 1'b0;
    cycle();
    chk("bp_release_count", tx_count, 16'd2);
    chk("bp_release_valid", L_valid_in, 1'b0);

    // Latency wrap: timestamp 250 arriving at now=4.
    apply_reset(4'd2);
    idle(4);
    send_rx(4'h9, 4'h2, 8'd250, 22'h00055, 2'b10);
    chk("wrap_rx_valid", rx_valid, 1'b1);
    chk("wrap_latency", rx_latency, 8'd10);
    chk("wrap_src", rx_src, 4'h9);
    chk("wrap_rx_count", rx_count, 16'd1);

    // Misroute, then saturate err_count.
    send_rx(4'h1, 4'h5, 8'd0, 22'h3, 2'b00);
    chk("misroute_err", err_count, 8'd1);
    chk("misroute_rx_count", rx_count, 16'd1);
    for (int i = 0; i < 300; i++) begin
      send_rx(4'($urandom_range(0, 15)), 4'h5, 8'($urandom), 22'($urandom), 2'($urandom));
    end
    chk("misroute_sat", err_count, 8'd255);

    // FIFO full, overflow drop, then simultaneous push/pop while full.
    apply_reset(4'd2);
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_rx(4'(i + 1), 4'h2, 8'd0, 22'(i * 7), 2'(i));
      if (i == 3) chk("ff_full_after4", rx_full, 1'b1);
    end
    chk("ff_drop_err", err_count, 8'd1);
    chk("ff_rx_count", rx_count, 16'd4);
    rx_ready = 1'b1;
    send_rx(4'hC, 4'h2, 8'd0, 22'h12345, 2'b01);
    rx_ready = 1'b0;
    chk("ff_pushpop_err", err_count, 8'd1);
    chk("ff_pushpop_full", rx_full, 1'b1);
    chk("ff_pushpop_count", rx_count, 16'd5);
    chk("ff_new_head", rx_src, 4'h2);

    // Asynchronous reset while SEND is stalled and the FIFO holds 2 entries.
    apply_reset(4'd2);
    send_rx(4'h4, 4'h2, 8'd0, 22'h11, 2'b00);
    send_rx(4'h5, 4'h2, 8'd0, 22'h22, 2'b01);
    tx_valid = 1'b1;
    tx_dst   = 4'h6;
    cycle();
    tx_valid = 1'b0;
    full     = 1'b1;
    cycle();
    chk("mid_pre_valid", L_valid_in, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_reset_zero("mid");
    hold_and_release(4'd2);

    // Randomized traffic against the model.
    apply_reset(4'($urandom_range(0, 15)));
    for (int i = 0; i < 3000; i++) begin
      if ((i % 700) == 699) node_id = 4'($urandom_range(0, 15));
      tx_valid    = ($urandom_range(0, 99) < 50);
      tx_dst      = 4'($urandom);
      tx_type     = 2'($urandom);
      tx_payload  = 22'($urandom);
      full        = ($urandom_range(0, 99) < 30);
      L_valid_out = ($urandom_range(0, 99) < 60);
      L_data_out  = {4'($urandom),
                     ($urandom_range(0, 99) < 75) ? node_id : 4'($urandom),
                     8'($urandom), 22'($urandom), 2'($urandom)};
      rx_ready    = ($urandom_range(0, 99) < 45);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
